alu_share_arb: RTL

- Sequences the 32-bit combinational ALU and shares it between two requesters (req0, req1) using valid/ready handshakes and round-robin arbitration.
- Latches the granted operands and opcode, then holds them stable on the ALU inputs for an opcode-dependent number of cycles so that multiply and divide can be timed as multicycle paths.
- Captures the ALU result and zero flag, and returns them on a single response channel tagged with the requester ID.

---
 rtl/alu_share_arb_if.sv | 41 ++++
 rtl/alu_share_arb.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Request/response bundle for alu_share_arb: two requesters plus a tagged response channel.
interface alu_share_arb_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_op1;
  logic [WIDTH-1:0] req0_op2;
  logic [3:0]       req0_sel;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_op1;
  logic [WIDTH-1:0] req1_op2;
  logic [3:0]       req1_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_zf;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_sel,
    input  req0_ready,
    output req1_valid, req1_op1, req1_op2, req1_sel,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_zf, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_sel,
    output req0_ready,
    input  req1_valid, req1_op1, req1_op2, req1_sel,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_zf, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between two requesters, with multicycle hold for mul/div.
// Define ALU_DIVZERO_CHK_EN to short-circuit divide-by-zero with an all-ones result and rsp_err.
module alu_share_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_arb_if.slave   bus,
  output logic             busy,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zf
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;

  logic             gnt1;
  logic             acc;
  logic [WIDTH-1:0] g_op1;
  logic [WIDTH-1:0] g_op2;
  logic [3:0]       g_sel;
  logic [CNT_W-1:0] g_cnt;

  // EXEC hold length minus one, indexed by opcode
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] sel);
    case (sel)
      4'b0011: return CNT_W'(MUL_LAT - 1);
      4'b0100: return CNT_W'(DIV_LAT - 1);
      default: return '0;
    endcase
  endfunction

`ifdef ALU_DIVZERO_CHK_EN
  logic g_divz;
  logic divz;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant: requester 1 wins when alone, or on a tie when requester 0 went last
  always_comb begin
    gnt1           = bus.req1_valid && (!bus.req0_valid || !last_grant);
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    busy           = (state != IDLE);
    if (state == IDLE) begin
      bus.req0_ready = bus.req0_valid && !gnt1;
      bus.req1_ready = gnt1;
    end
    acc   = bus.req0_ready || bus.req1_ready;
    g_op1 = gnt1 ? bus.req1_op1 : bus.req0_op1;
    g_op2 = gnt1 ? bus.req1_op2 : bus.req0_op2;
    g_sel = gnt1 ? bus.req1_sel : bus.req0_sel;
`ifdef ALU_DIVZERO_CHK_EN
    g_divz = (g_sel == 4'b0100) && (g_op2 == '0);
    g_cnt  = g_divz ? '0 : lat_m1(g_sel);
`else
    g_cnt  = lat_m1(g_sel);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_sel       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_res   <= '0;
      bus.rsp_zf    <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
`ifdef ALU_DIVZERO_CHK_EN
      bus.rsp_err   <= 1'b0;
      divz          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (acc) begin
          alu_op1    <= g_op1;
          alu_op2    <= g_op2;
          alu_sel    <= g_sel;
          bus.rsp_id <= gnt1;
          last_grant <= gnt1;
          cnt        <= g_cnt;
`ifdef ALU_DIVZERO_CHK_EN
          divz       <= g_divz;
`endif
        end
        EXEC: if (cnt == '0) begin
          bus.rsp_valid <= 1'b1;
`ifdef ALU_DIVZERO_CHK_EN
          bus.rsp_res   <= divz ? '1 : alu_res;
          bus.rsp_zf    <= divz ? 1'b0 : alu_zf;
          bus.rsp_err   <= divz;
`else
          bus.rsp_res   <= alu_res;
          bus.rsp_zf    <= alu_zf;
`endif
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifndef ALU_DIVZERO_CHK_EN
  assign bus.rsp_err = 1'b0;
`endif

endmodule
